// File: rtl/neuron_lut_loader_pkg.sv
// Shared types and constants for the runtime-loadable truth-table neuron.
package neuron_lut_pkg;

    localparam int DEF_IN_BITS  = 8;
    localparam int DEF_OUT_BITS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    // Number of table entries addressed by an in_bits-wide lookup code.
    function automatic int lut_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/neuron_lut_loader_if.sv
// Config-stream and lookup signals of the loader; master = host/datapath, slave = loader.
interface neuron_lut_loader_if
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
);
    logic                load_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_last;
    logic                load_done;
    logic                load_err;
    logic                table_valid;
    logic                lut_in_valid;
    logic [IN_BITS-1:0]  lut_in;
    logic                lut_out_valid;
    logic [OUT_BITS-1:0] lut_out;

    modport master (
        output load_start, cfg_valid, cfg_data, cfg_last, lut_in_valid, lut_in,
        input  cfg_ready, load_done, load_err, table_valid, lut_out_valid, lut_out
    );

    modport slave (
        input  load_start, cfg_valid, cfg_data, cfg_last, lut_in_valid, lut_in,
        output cfg_ready, load_done, load_err, table_valid, lut_out_valid, lut_out
    );
endinterface

// File: rtl/neuron_lut_loader_ram.sv
// Truth-table storage: one write port, asynchronous read, no reset.
module neuron_lut_ram
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IN_BITS-1:0]  waddr_i,
    input  logic [OUT_BITS-1:0] wdata_i,
    input  logic [IN_BITS-1:0]  raddr_i,
    output logic [OUT_BITS-1:0] rdata_o
);
    localparam int DEPTH = lut_depth(IN_BITS);

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem_q [DEPTH];

    // Write the streamed entry; contents survive reset, validity is tracked by the FSM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/neuron_lut_loader.sv
// Loads a streamed truth table into distributed RAM, then serves registered lookups.
module neuron_lut_loader
    import neuron_lut_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic               clk,
    input  logic               rst,
    neuron_lut_loader_if.slave bus
);
    localparam int DEPTH = lut_depth(IN_BITS);
    // One extra bit so the end-of-table compare never relies on wrap-around.
    localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS+1)'(DEPTH - 1);
    localparam logic [IN_BITS:0] ADDR_ONE  = (IN_BITS+1)'(1);

    state_e              state_q;
    logic [IN_BITS:0]    waddr_q, waddr_d;
    logic                cfg_ready_q;
    logic                table_valid_q;
    logic                load_done_q;
    logic                load_err_q;
    logic                lut_out_valid_q;
    logic [OUT_BITS-1:0] lut_out_q;

    logic                ram_we;
    logic                at_last;
    logic [OUT_BITS-1:0] ram_rdata;

    // An entry offered alongside load_start is dropped: the restart wins.
    assign ram_we  = (state_q == LOAD) && bus.cfg_valid && !bus.load_start;
    assign at_last = (waddr_q == LAST_ADDR);
    assign waddr_d = waddr_q + ADDR_ONE;

    neuron_lut_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (waddr_q[IN_BITS-1:0]),
        .wdata_i (bus.cfg_data),
        .raddr_i (bus.lut_in),
        .rdata_o (ram_rdata)
    );

    // Load/serve FSM with all handshake and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            waddr_q         <= '0;
            cfg_ready_q     <= 1'b0;
            table_valid_q   <= 1'b0;
            load_done_q     <= 1'b0;
            load_err_q      <= 1'b0;
            lut_out_valid_q <= 1'b0;
            lut_out_q       <= '0;
        end else begin
            load_done_q     <= 1'b0;
            lut_out_valid_q <= 1'b0;

            // Lookup issued while ACTIVE is served even if a reload starts this cycle.
            if (state_q == ACTIVE && bus.lut_in_valid) begin
                lut_out_valid_q <= 1'b1;
                lut_out_q       <= ram_rdata;
            end

            case (state_q)
                IDLE: begin
                    if (bus.load_start) begin
                        state_q     <= LOAD;
                        cfg_ready_q <= 1'b1;
                        waddr_q     <= '0;
                        load_err_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.load_start) begin
                        waddr_q    <= '0;
                        load_err_q <= 1'b0;
                    end else if (bus.cfg_valid) begin
                        if (bus.cfg_last && at_last) begin
                            state_q       <= ACTIVE;
                            cfg_ready_q   <= 1'b0;
                            table_valid_q <= 1'b1;
                            load_done_q   <= 1'b1;
                            waddr_q       <= '0;
                        end else if (bus.cfg_last || at_last) begin
                            state_q     <= IDLE;
                            cfg_ready_q <= 1'b0;
                            load_err_q  <= 1'b1;
                            waddr_q     <= '0;
                        end else begin
                            waddr_q <= waddr_d;
                        end
                    end
                end
                ACTIVE: begin
                    if (bus.load_start) begin
                        state_q       <= LOAD;
                        cfg_ready_q   <= 1'b1;
                        table_valid_q <= 1'b0;
                        waddr_q       <= '0;
                        load_err_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    cfg_ready_q   <= 1'b0;
                    table_valid_q <= 1'b0;
                    waddr_q       <= '0;
                end
            endcase
        end
    end

    assign bus.cfg_ready     = cfg_ready_q;
    assign bus.table_valid   = table_valid_q;
    assign bus.load_done     = load_done_q;
    assign bus.load_err      = load_err_q;
    assign bus.lut_out_valid = lut_out_valid_q;
    assign bus.lut_out       = lut_out_q;

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Scoreboard bench: driver pushes expected lookup results, negedge monitor pops and compares.
module tb_neuron_lut_loader;
    localparam int IB    = 8;
    localparam int OB    = 2;
    localparam int DEPTH = 1 << IB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_lut_loader_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus ();

    neuron_lut_loader #(.IN_BITS(IB), .OUT_BITS(OB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [OB-1:0] data;
        int            cyc;
        logic [IB-1:0] addr;
    } exp_t;

    exp_t          q[$];
    logic [OB-1:0] model_ram [DEPTH];
    bit            model_active = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: count accepted config beats and score every lookup result.
    always @(negedge clk) begin
        if (bus.cfg_valid === 1'b1 && bus.cfg_ready === 1'b1) hs_cnt++;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk($sformatf("lut_out_missing a=%0h", q[0].addr), 0, 1);
            void'(q.pop_front());
        end
        if (bus.lut_out_valid !== 1'b0) begin
            if (q.size() == 0) begin
                chk("lut_out_valid_unexpected", 32'(bus.lut_out_valid), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("lut_out a=%0h", e.addr), 32'(bus.lut_out), 32'(e.data));
                chk("lut_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [IB-1:0] a);
        bus.lut_in_valid = 1'b1;
        bus.lut_in       = a;
        if (model_active) q.push_back('{model_ram[a], cyc + 1, a});
        step;
        bus.lut_in_valid = 1'b0;
    endtask

    task automatic rand_lookups(input int n);
        for (int k = 0; k < n; k++) lookup(IB'($urandom));
    endtask

    task automatic drain;
        repeat (3) step;
        chk("scoreboard_empty", q.size(), 0);
    endtask

    // mode 0: entry = addr mod 4, 1: all 2'b01, 2: random. gap = % of idle cycles.
    task automatic do_load(input bit start, input int gap, input int mode,
                           input int last_at, input int abort_at);
        int            i = 0;
        int            n = 0;
        bit            v, hs, ok, done;
        logic [OB-1:0] d;
        ok = 1'b0;
        done = 1'b0;
        if (start) begin
            bus.load_start = 1'b1;
            step;
            bus.load_start = 1'b0;
            model_active = 1'b0;
            chk("load_err_cleared", 32'(bus.load_err), 0);
            chk("cfg_ready_in_load", 32'(bus.cfg_ready), 1);
        end
        hs_cnt = 0;
        while (!done && n < 5000) begin
            if (i == abort_at) return;
            v = ($urandom_range(99) >= gap);
            case (mode)
                0:       d = OB'(i);
                1:       d = 2'b01;
                default: d = OB'($urandom);
            endcase
            bus.cfg_valid = v;
            bus.cfg_data  = d;
            bus.cfg_last  = (i == last_at);
            hs = v && (bus.cfg_ready === 1'b1);
            step;
            n++;
            bus.cfg_valid = 1'b0;
            bus.cfg_last  = 1'b0;
            if (hs) begin
                model_ram[i] = d;
                i++;
                if (i - 1 == last_at || i == DEPTH) begin
                    done = 1'b1;
                    ok = (i == DEPTH) && (last_at == DEPTH - 1);
                end
            end
        end
        if (!done) begin
            chk("load_timeout", 0, 1);
            return;
        end
        if (ok) begin
            chk("load_done_pulse", 32'(bus.load_done), 1);
            chk("table_valid_up", 32'(bus.table_valid), 1);
            chk("load_err_clean", 32'(bus.load_err), 0);
            chk("write_count", hs_cnt, DEPTH);
            model_active = 1'b1;
            step;
            chk("load_done_one_cycle", 32'(bus.load_done), 0);
        end else begin
            chk("load_err_set", 32'(bus.load_err), 1);
            chk("table_valid_err", 32'(bus.table_valid), 0);
            chk("cfg_ready_err_idle", 32'(bus.cfg_ready), 0);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.load_start   = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_data     = '0;
        bus.cfg_last     = 1'b0;
        bus.lut_in_valid = 1'b0;
        bus.lut_in       = '0;
        step;
        step;
        rst = 1'b0;
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        chk("rst_table_valid", 32'(bus.table_valid), 0);
        chk("rst_load_done", 32'(bus.load_done), 0);
        chk("rst_load_err", 32'(bus.load_err), 0);
        chk("rst_lut_out", 32'(bus.lut_out), 0);

        // Lookup before any table: ignored.
        lookup(8'h00);
        chk("idle_lut_out_valid", 32'(bus.lut_out_valid), 0);
        chk("idle_table_valid", 32'(bus.table_valid), 0);
        drain;

        // Identity-mod-4 table, no gaps, then back-to-back lookups.
        do_load(1'b1, 0, 0, DEPTH - 1, -1);
        lookup(8'h00);
        lookup(8'h37);
        lookup(8'hFF);
        rand_lookups(10);
        drain;

        // Same table with ~50% cfg_valid gaps.
        do_load(1'b1, 50, 0, DEPTH - 1, -1);
        lookup(8'h00);
        lookup(8'h37);
        lookup(8'hFF);
        rand_lookups(10);
        drain;

        // Early cfg_last at entry 100: error, back in IDLE, lookups ignored.
        do_load(1'b1, 0, 2, 100, -1);
        lookup(8'h05);
        drain;
        // Missing cfg_last on the final entry: also an error.
        do_load(1'b1, 0, 2, 300, -1);
        drain;
        // Random table with gaps.
        do_load(1'b1, 30, 2, DEPTH - 1, -1);
        rand_lookups(40);
        drain;

        // All-01 table, then reload while a lookup is in flight.
        do_load(1'b1, 0, 1, DEPTH - 1, -1);
        bus.load_start = 1'b1;
        lookup(8'h10);
        bus.load_start = 1'b0;
        model_active = 1'b0;
        chk("reload_table_valid_drop", 32'(bus.table_valid), 0);
        chk("reload_cfg_ready", 32'(bus.cfg_ready), 1);
        rand_lookups(4);
        do_load(1'b0, 0, 0, DEPTH - 1, -1);
        lookup(8'h37);
        lookup(8'hFF);
        drain;

        // Reset in the middle of a load.
        do_load(1'b1, 0, 2, DEPTH - 1, 50);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("midrst_cfg_ready", 32'(bus.cfg_ready), 0);
        chk("midrst_table_valid", 32'(bus.table_valid), 0);
        chk("midrst_load_done", 32'(bus.load_done), 0);
        chk("midrst_load_err", 32'(bus.load_err), 0);
        chk("midrst_lut_out_valid", 32'(bus.lut_out_valid), 0);
        chk("midrst_lut_out", 32'(bus.lut_out), 0);
        model_active = 1'b0;
        do_load(1'b1, 20, 2, DEPTH - 1, -1);
        rand_lookups(30);
        drain;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_lut_loader.md
# neuron_lut_loader

Runtime-programmable truth-table neuron: the writer side of the fixed neuron LUTs produced by the flow. It accepts a streamed truth table (one OUT_BITS-wide entry per input code, in ascending address order), stores it in distributed RAM, and then answers lookups with one cycle of latency. It sits between the configuration path, which carries per-neuron tables from the host, and the layer datapath, where it replaces a hard-coded LUT of the same IN_BITS/OUT_BITS shape.

## Interface
Parameters:
- IN_BITS, 8, lookup address width (fan-in × input bit width); table depth is 2^IN_BITS.
- OUT_BITS, 2, entry width / neuron output width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  pulse: begin a new table load (erases current table validity).
- cfg_valid  in  1  config entry present.
- cfg_ready  out  1  block accepts entry this cycle.
- cfg_data  in  OUT_BITS  entry for the current write address.
- cfg_last  in  1  marks the final entry of the table.
- load_done  out  1  one-cycle pulse: table loaded successfully.
- load_err  out  1  sticky: cfg_last position mismatch; cleared by rst or load_start.
- table_valid  out  1  high while lookups are served.
- lut_in_valid  in  1  lookup request.
- lut_in  in  IN_BITS  lookup address.
- lut_out_valid  out  1  registered lookup result valid.
- lut_out  out  OUT_BITS  registered lookup result.

## Operation
- FSM states: IDLE, LOAD, ACTIVE.
- Reset: state IDLE, write address 0, cfg_ready 0, load_done 0, load_err 0, table_valid 0, lut_out_valid 0, lut_out 0. RAM contents are not reset.
- IDLE: cfg_ready 0; lookups ignored. load_start → LOAD.
- LOAD: cfg_ready 1. Each handshake (cfg_valid & cfg_ready) writes cfg_data at the write address, then increments it.
  - Handshake at address 2^IN_BITS−1 with cfg_last=1 → ACTIVE, load_done pulses next cycle, address → 0.
  - cfg_last=1 at any other address, or cfg_last=0 at the final address → entry is still written; load_err set; state → IDLE; address → 0.
  - cfg_valid low: hold, no write.
  - load_start in LOAD: restart at address 0, clear load_err; entry handshaked in the same cycle is discarded.
- ACTIVE: table_valid 1; cfg_ready 0. A lookup with lut_in_valid=1 registers RAM[lut_in] into lut_out and sets lut_out_valid the next cycle; otherwise lut_out_valid 0 and lut_out holds its value.
  - load_start in ACTIVE: a lookup presented in the same cycle is still served; state → LOAD; table_valid drops the next cycle.
- Lookups are served only in ACTIVE. A lookup in any other state yields lut_out_valid 0.
- Write-address counter is IN_BITS+1 wide internally, so overflow detection never depends on wrap-around.

## Timing
- Lookup latency: 1 cycle (address at edge N, result valid after edge N+1); throughput 1/cycle.
- Load: 2^IN_BITS accepted handshakes minimum (256 for defaults); no bubbles are inserted by the block.
- load_done asserts the cycle after the final handshake, coincident with table_valid rising.
- rst during LOAD or ACTIVE: reset values take effect at the next edge; any partial table is discarded logically (table_valid 0).

## Structure
- Shared package neuron_lut_pkg: FSM state enum (IDLE/LOAD/ACTIVE), default IN_BITS/OUT_BITS constants, depth function 2^IN_BITS.
- Sub-module neuron_lut_ram: single write port, asynchronous read, (*rom_style/ram_style = "distributed"*), no reset. The top-level block registers the read output.

## Test plan
- Reset, then lookup lut_in=8'h00 with lut_in_valid=1 → lut_out_valid stays 0; table_valid 0; cfg_ready 0.
- Load identity-mod-4 table (entry = addr[1:0]), cfg_last on entry 255 → load_done pulse one cycle after handshake 255. Then lookups 8'h00, 8'h37, 8'hFF → 2'b00, 2'b11, 2'b11, each one cycle later, back-to-back.
- Load with random cfg_valid gaps (~50% duty) → same lookup results; exactly 256 writes occur.
- cfg_last asserted on entry 100 → load_err=1, state IDLE, table_valid 0. Next load_start clears load_err.
- Load all-2'b01, then issue load_start while lut_in=8'h10 is valid → that lookup returns 2'b01. Following lookups give lut_out_valid 0 until the new load completes.
- rst mid-load at entry 50 → all outputs at reset values next cycle. A full subsequent load works normally.
